// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, FSM state encoding, working-state struct and bit helpers
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] shr(input logic [31:0] x, input int n);
    return x >> n;
  endfunction
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
endpackage

// File: rtl/sha256_compress_if.sv
// sha256_compress_if: request/response bundle between a hash requester and the compression engine
interface sha256_compress_if;
  logic         start;
  logic [511:0] block;
  logic [255:0] hash_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
  modport master (output start, block, hash_in, input busy, done, hash_out);
  modport slave (input start, block, hash_in, output busy, done, hash_out);
endinterface

// File: rtl/sha256_compress_round.sv
// sha256_round: one combinational SHA-256 round producing the next a..h
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output work_t       nxt
);
  logic [31:0] t1, t2;
  assign t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
  assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
  assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                 e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: iterative 64-round SHA-256 compression, one round per clock
module sha256_compress
  import sha256_pkg::*;
(
  input logic clk,
  input logic rst_n,
  sha256_compress_if.slave bus
);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ROUND = ROUND;
  localparam logic [1:0] S_FINAL = FINAL;
  logic [1:0]   state;
  logic [5:0]   t;
  logic [31:0]  w [16];
  logic [31:0]  w_new;
  work_t        hv, wv, nxt;
  logic [255:0] hash_q;
  logic         done_q;
  assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  assign bus.busy = state != S_IDLE;
  assign bus.done = done_q;
  assign bus.hash_out = hash_q;
  sha256_round u_round (.cur(wv), .w(w[0]), .k(K[t]), .nxt(nxt));
  // FSM: accept a block, run 64 rounds with a sliding schedule window, then fold into the chaining value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      t      <= '0;
      hv     <= '0;
      wv     <= '0;
      hash_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          for (int i = 0; i < 16; i++) w[i] <= bus.block[511 - 32*i -: 32];
          hv    <= work_t'(bus.hash_in);
          wv    <= work_t'(bus.hash_in);
          t     <= '0;
          state <= S_ROUND;
        end
        S_ROUND: begin
          wv <= nxt;
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          t     <= t + 6'd1;
          state <= t == 6'd63 ? S_FINAL : S_ROUND;
        end
        S_FINAL: begin
          hash_q <= {hv.a + wv.a, hv.b + wv.b, hv.c + wv.c, hv.d + wv.d,
                     hv.e + wv.e, hv.f + wv.f, hv.g + wv.g, hv.h + wv.h};
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
